// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one bit per clock.
// Turns a 7-bit operand into a packed two-digit BCD word plus an overflow flag.
module bin_to_bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd,
    output logic       ovf
);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  ones_q, ones_d;
    logic [6:0]  bin_q, bin_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  bcd_q, bcd_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [3:0]  tensAdj;
    logic [3:0]  onesAdj;
    logic [16:0] shiftVec;

    // Hundreds never exceeds 1, so only the two lower digits need the +3 step.
    always_comb begin
        tensAdj  = (tens_q >= 4'd5) ? tens_q + 4'd3 : tens_q;
        onesAdj  = (ones_q >= 4'd5) ? ones_q + 4'd3 : ones_q;
        shiftVec = {hund_q, tensAdj, onesAdj, bin_q} << 1;
    end

    always_comb begin
        state_d = state_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    hund_d  = 2'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                hund_d = shiftVec[16:15];
                tens_d = shiftVec[14:11];
                ones_d = shiftVec[10:7];
                bin_d  = shiftVec[6:0];
                cnt_d  = cnt_q + 3'd1;
                // Results are published only on the last iteration so the
                // outputs never expose partially converted digits.
                if (cnt_q == 3'd6) begin
                    bcd_d   = shiftVec[14:7];
                    ovf_d   = (shiftVec[16:15] != 2'd0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hund_q  <= 2'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            bin_q   <= 7'd0;
            cnt_q   <= 3'd0;
            bcd_q   <= 8'h00;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CONV);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: latency, overflow, ignored start,
// back-to-back, mid-conversion reset and a full 0..127 sweep.
module tb_bin_to_bcd_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] bin;
    logic       busy;
    logic       done;
    logic [7:0] bcd;
    logic       ovf;

    int checks;
    int failures;

    bin_to_bcd_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion at the next edge and follows it to its done pulse.
    task automatic applyStimulus(input logic [6:0] value, input logic [7:0] expBcd,
                                 input logic expOvf, input string tag,
                                 input bit checkTiming);
        int lat;
        int busyCnt;
        bit overlap;
        start = 1'b1;
        bin   = value;
        stepClock();
        start = 1'b0;
        lat     = 0;
        busyCnt = 0;
        overlap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) break;
            if (busy) busyCnt++;
            stepClock();
            lat++;
        end
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_bcd"}, bcd, expBcd);
        checkOutput({tag, "_ovf"}, ovf, expOvf);
        if (checkTiming) begin
            checkOutput({tag, "_latency"}, lat, 7);
            checkOutput({tag, "_busyCycles"}, busyCnt, 7);
            checkOutput({tag, "_busyDoneOverlap"}, overlap, 1'b0);
            stepClock();
            checkOutput({tag, "_donePulse"}, done, 1'b0);
            checkOutput({tag, "_bcdHold"}, bcd, expBcd);
        end
    endtask

    initial begin
        int lat;
        int doneCnt;
        logic [7:0] expBcd;
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        start = 1'b0;
        bin   = 7'd0;

        // Reset
        stepClock();
        stepClock();
        checkOutput("reset_bcd", bcd, 8'h00);
        checkOutput("reset_ovf", ovf, 1'b0);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        rst = 1'b0;
        stepClock();

        // Single conversions with timing
        applyStimulus(7'd0,  8'h00, 1'b0, "conv0",  1'b1);
        applyStimulus(7'd45, 8'h45, 1'b0, "conv45", 1'b1);
        applyStimulus(7'd99, 8'h99, 1'b0, "conv99", 1'b1);

        // Overflow
        applyStimulus(7'd100, 8'h00, 1'b1, "conv100", 1'b1);
        applyStimulus(7'd127, 8'h27, 1'b1, "conv127", 1'b1);

        // Ignored start at E3
        start = 1'b1;
        bin   = 7'd37;
        stepClock();
        start = 1'b0;
        stepClock();
        stepClock();
        start = 1'b1;
        bin   = 7'd88;
        stepClock();
        start = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                doneCnt++;
                checkOutput("ignStart_bcd", bcd, 8'h37);
            end
            stepClock();
        end
        checkOutput("ignStart_doneCount", doneCnt, 1);
        checkOutput("ignStart_idle", busy, 1'b0);

        // Back-to-back with start held high
        start = 1'b1;
        bin   = 7'd58;
        stepClock();
        bin = 7'd9;
        lat = 0;
        while (!done && lat < 20) begin
            stepClock();
            lat++;
        end
        checkOutput("b2b_first_latency", lat, 7);
        checkOutput("b2b_first_bcd", bcd, 8'h58);
        lat = 0;
        stepClock();
        lat++;
        while (!done && lat < 20) begin
            stepClock();
            lat++;
        end
        start = 1'b0;
        checkOutput("b2b_spacing", lat, 8);
        checkOutput("b2b_second_bcd", bcd, 8'h09);
        checkOutput("b2b_second_ovf", ovf, 1'b0);
        stepClock();
        stepClock();
        checkOutput("b2b_noThird", busy, 1'b0);

        // Reset at E4 of a conversion of 73
        start = 1'b1;
        bin   = 7'd73;
        stepClock();
        start = 1'b0;
        stepClock();
        stepClock();
        stepClock();
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        checkOutput("midRst_busy", busy, 1'b0);
        checkOutput("midRst_done", done, 1'b0);
        checkOutput("midRst_bcd", bcd, 8'h00);
        checkOutput("midRst_ovf", ovf, 1'b0);
        doneCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) doneCnt++;
            stepClock();
        end
        checkOutput("midRst_noDone", doneCnt, 0);
        checkOutput("midRst_bcdHeld", bcd, 8'h00);

        // Exhaustive sweep
        for (int v = 0; v < 128; v++) begin
            expBcd = {4'((v % 100) / 10), 4'(v % 10)};
            applyStimulus(7'(v), expBcd, (v > 99), $sformatf("sweep%0d", v), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the two-digit BCD adder. It turns a 7-bit binary operand into the packed two-digit BCD word the adder takes on `A`/`B`. It also flags values that cannot be represented in two BCD digits.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  rising-edge clock; the block's only clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a conversion; sampled only in IDLE
- `bin`  in  7  binary operand, 0..127; captured on the accepting edge
- `busy`  out  1  high while a conversion is in progress
- `done`  out  1  single-cycle pulse; `bcd`/`ovf` are valid from this cycle onward
- `bcd`  out  8  packed result: `[7:4]` is the tens digit, `[3:0]` is the ones digit, each 0..9
- `ovf`  out  1  high when the last converted `bin` was greater than 99

## Operation
- States:
  - IDLE: waits for `start`.
  - CONV: performs the shift iterations.
- IDLE with `start`=1 at an edge:
  - load the shift register with `bin`;
  - clear the BCD scratch: hundreds 2 bits, tens 4 bits, ones 4 bits;
  - clear the iteration counter to 0;
  - go to CONV.
- IDLE with `start`=0: remain in IDLE; all outputs hold.
- CONV, every edge:
  - Correct: each of the tens and ones nibbles that is ≥5 gets +3. The hundreds field needs no correction (its maximum is 1).
  - Shift: shift the 17-bit concatenation {hundreds, tens, ones, binreg} left by 1.
  - Increment the counter.
- CONV, on the 7th iteration (counter==6):
  - register the final tens/ones into `bcd`;
  - set `ovf` = (hundreds != 0);
  - assert `done` for one cycle;
  - return to IDLE.
- Arithmetic guarantees:
  - After 7 iterations, tens and ones are each 0..9. The hundreds value is 0 or 1.
  - For `bin` > 99, `bcd` holds `bin` mod 100 in BCD and `ovf`=1. Example: 127 gives 0x27 with `ovf`=1.
- `start` while in CONV is ignored. It is not queued, and `bin` changes do not affect the conversion in flight.
- `bcd`/`ovf` hold their last completed result until the next completion. They never show intermediate values.
- `rst`=1 at any edge, including mid-conversion:
  - next state is IDLE; the counter and scratch registers are cleared;
  - `busy`=0, `done`=0, `bcd`=8'h00, `ovf`=0;
  - the aborted conversion never produces `done`;
  - `rst` has priority over `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=8'h00, `ovf`=0.
- `start` is accepted at edge E0.
- `busy` is high in the 7 cycles following E0 (E0 through E7).
- Iterations occur at edges E1..E7.
- At E7, `bcd`/`ovf` update, `done` rises and `busy` falls.
- Latency: `done` is high in the cycle after E7, exactly 7 clocks after the accepting edge.
- `done` is high for exactly one cycle. During that cycle the block is in IDLE, so a `start` sampled at E8 is accepted.
- Throughput: back-to-back conversions can start every 8 clocks. The maximum rate comes from holding `start` high.
- `busy` and `done` are never high in the same cycle.

## Test plan
- **Reset:** hold `rst` for 2 cycles.
  - Outputs read `bcd`=00, `ovf`=0, `busy`=0, `done`=0.
- **Single conversions and latency:** convert each of `bin`=0, 45, 99.
  - Results: `bcd`=0x00, 0x45, 0x99, each with `ovf`=0.
  - `done` pulses exactly 7 clocks after the accepting edge.
  - `busy` is high for exactly 7 cycles.
- **Overflow:** convert `bin`=100 and `bin`=127.
  - Results: `bcd`=0x00 with `ovf`=1, and `bcd`=0x27 with `ovf`=1.
- **Ignored start:** start 37, then pulse `start` with `bin`=88 at E3.
  - Exactly one `done` is produced, with `bcd`=0x37.
  - No second conversion follows.
- **Back-to-back with `start` held high:** `bin`=58 then `bin`=9.
  - Two `done` pulses 8 clocks apart, with `bcd`=0x58 then `bcd`=0x09.
- **Reset mid-conversion and exhaustive sweep:**
  - Assert `rst` at E4 of a 73 conversion: no `done`, and outputs return to reset values.
  - Then sweep `bin`=0..127: for every value, `bcd` equals `bin` mod 100 in BCD and `ovf` equals (`bin` > 99).
